// File: rtl/pb_debounce.sv
// Push-button conditioner: per-channel 2-flop synchroniser, bounce filter FSM,
// debounced level plus press/release pulses. PB_DEBOUNCE_RELEASE_PULSE_EN enables released.

module pb_debounce_ch #(
  parameter int DB_CYCLES = 1000,
  parameter int CW        = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pressed,
  output logic released
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q, sync_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          pressed_q, pressed_d;
  logic          sync;

  assign sync    = sync_q[1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign sync_d  = {sync_q[0], btn_in};

`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
  logic released_q, released_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pressed_d = 1'b0;
`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
    released_d = 1'b0;
`endif
    case (state_q)
      S_LOW: if (sync) begin
        state_d = S_RISE;
        cnt_d   = CNT_ONE;
      end
      S_RISE: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HIGH;
          level_d   = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HIGH: if (!sync) begin
        state_d = S_FALL;
        cnt_d   = CNT_ONE;
      end
      S_FALL: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // level falls on the same edge whether or not the pulse is built
          state_d = S_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
          released_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) released_q <= 1'b0;
    else     released_q <= released_d;
  end
  assign released = released_q;
`else
  assign released = 1'b0;
`endif

  assign level   = level_q;
  assign pressed = pressed_q;
endmodule

module pb_debounce #(
  parameter int N         = 2,
  parameter int DB_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] pressed,
  output logic [N-1:0] released
);
  for (genvar g = 0; g < N; g++) begin : g_ch
    pb_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in[g]),
      .level    (btn_level[g]),
      .pressed  (pressed[g]),
      .released (released[g])
    );
  end
endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: run-length reference model feeds a scoreboard queue,
// a negedge monitor pops and compares; directed latency/reset/system scenarios plus random.
module tb_pb_debounce;
  localparam int N  = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, pressed, released;

  always #5 clk = ~clk;

  pb_debounce #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .pressed(pressed), .released(released)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl;
  int           m_run[N];

  // Reference: the filter sees btn_in two edges late; level flips once it has
  // disagreed with the current level for DB consecutive samples.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lvl = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      sb.delete();
    end else begin
      logic [N-1:0] s;
      exp_t e;
      s = hist.pop_front();
      hist.push_back(btn_in);
      e = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] != m_lvl[c]) m_run[c]++;
        else                  m_run[c] = 0;
        if (m_run[c] == DB) begin
          m_run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) e.prs[c] = 1'b1;
`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
          else          e.rel[c] = 1'b1;
`endif
        end
      end
      e.lvl = m_lvl;
      sb.push_back(e);
    end
  end

  int prs_cnt[N];
  int rel_cnt[N];

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_hold", {btn_level, pressed, released}, '0);
    end else if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("scoreboard", {btn_level, pressed, released}, {e.lvl, e.prs, e.rel});
      for (int c = 0; c < N; c++) begin
        if (pressed[c])  prs_cnt[c]++;
        if (released[c]) rel_cnt[c]++;
      end
    end
  end

  // Minimal stand-in for the downstream equality comparator.
  logic [3:0] cmp_in = '0;
  logic [3:0] r1, r2;
  int         ld1, ld2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0; r2 <= '0; ld1 = 0; ld2 = 0;
    end else begin
      if (pressed[0]) begin r1 <= cmp_in; ld1 = ld1 + 1; end
      if (pressed[1]) begin r2 <= cmp_in; ld2 = ld2 + 1; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call right after driving the step at a negedge; counts edges from the sampling edge.
  task automatic measure_rise(input int ch, input string name);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!btn_level[ch] && lat < 40);
    chk(name, lat, DB + 2);
    chk({name, "_pulse"}, {31'd0, pressed[ch]}, 1);
    @(negedge clk);
  endtask

  task automatic press(input int ch);
    btn_in[ch] = 1'b1; tick(DB + 6);
    btn_in[ch] = 1'b0; tick(DB + 6);
  endtask

  initial begin
    int p1;
    int r0b, r1b, l1, l2;
    for (int c = 0; c < N; c++) begin prs_cnt[c] = 0; rel_cnt[c] = 0; end
    rst = 1'b1;
    tick(3);
    chk("reset_state", {btn_level, pressed, released}, '0);
    rst = 1'b0;
    tick(2);

    // clean press on channel 0
    btn_in[0] = 1'b1;
    measure_rise(0, "clean_latency");
    chk("clean_ch1_idle", {30'd0, btn_level[1], pressed[1]}, 0);
    @(posedge clk); #1;
    chk("clean_pulse_width", {31'd0, pressed[0]}, 0);
    tick(20);
    chk("hold_no_retrigger", prs_cnt[0], 1);
    btn_in[0] = 1'b0; tick(12);

    // bounce: 1,0,1,0 in 2-cycle widths then hold
    btn_in[0] = 1'b1; tick(2); btn_in[0] = 1'b0; tick(2);
    btn_in[0] = 1'b1; tick(2); btn_in[0] = 1'b0; tick(2);
    btn_in[0] = 1'b1;
    measure_rise(0, "bounce_latency");
    tick(10);
    chk("bounce_one_pulse", prs_cnt[0], 2);
    btn_in[0] = 1'b0; tick(12);

    // short glitch on channel 1
    p1 = prs_cnt[1];
    btn_in[1] = 1'b1; tick(3); btn_in[1] = 1'b0; tick(12);
    chk("glitch_no_press", prs_cnt[1], p1);
    chk("glitch_level", {31'd0, btn_level[1]}, 0);

    // simultaneous press and release
    btn_in = '1;
    measure_rise(0, "simul_latency");
    tick(1);
    r0b = rel_cnt[0]; r1b = rel_cnt[1];
    btn_in = '0; tick(12);
`ifdef PB_DEBOUNCE_RELEASE_PULSE_EN
    chk("simul_release", (rel_cnt[0] - r0b) + (rel_cnt[1] - r1b), 2);
`else
    chk("simul_release", (rel_cnt[0] - r0b) + (rel_cnt[1] - r1b), 0);
`endif

    // asynchronous reset with both levels high
    btn_in = '1; tick(12);
    chk("pre_reset_level", {30'd0, btn_level}, 3);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("async_reset", {btn_level, pressed, released}, '0);
    @(negedge clk);
    rst = 1'b0;
    measure_rise(0, "post_reset_latency");
    btn_in = '0; tick(12);

    // downstream comparator
    l1 = ld1; l2 = ld2;
    cmp_in = 4'b0110; press(0); press(1);
    chk("cmp_eq_match", {31'd0, r1 == r2}, 1);
    chk("cmp_r1", r1, 4'b0110);
    cmp_in = 4'b0111; press(0);
    cmp_in = 4'b0011; press(1);
    chk("cmp_eq_diff", {31'd0, r1 == r2}, 0);
    chk("cmp_loads", (ld1 - l1) * 16 + (ld2 - l2), 2 * 16 + 2);

    // random bouncy segments
    for (int i = 0; i < 400; i++) begin
      btn_in = N'($urandom);
      tick($urandom_range(1, 10));
    end
    btn_in = '0; tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
